width_8to12_arb: RTL and testbench

WIDTH_8TO12_ARB -- requirements
Module: width_8to12_arb

---
 rtl/width_8to12_arb.sv | 129 ++++++++++++
 tb/tb_width_8to12_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/width_8to12_arb.sv
// Two-source byte arbiter feeding a shared 8-to-12 packer.
// Grants whole 3-byte groups (two 12-bit words) and alternates round-robin between groups.
module grp_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

module width_8to12_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             pk_valid,
  output logic [7:0]       pk_data,
  output logic             pk_src,
  output logic             grp_done,
  output logic             busy,
  output logic [CNT_W-1:0] grp_cnt0,
  output logic [CNT_W-1:0] grp_cnt1
);
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       gnt, gnt_nxt;
  logic       prio, prio_nxt;
  logic [1:0] bcnt, bcnt_nxt;
  logic [1:0] vld;
  logic [1:0][7:0] dat;
  logic       acc, last;
  logic [1:0][CNT_W-1:0] cnt;

  // Both valid -> the priority source wins; otherwise whichever is valid.
  function automatic logic pick(input logic p, input logic [1:0] v);
    return (&v) ? p : v[1];
  endfunction

  assign vld        = {req1_valid, req0_valid};
  assign dat        = {req1_data, req0_data};
  assign req0_ready = (state == XFER) && !gnt;
  assign req1_ready = (state == XFER) && gnt;
  assign busy       = (state == XFER);
  assign acc        = (state == XFER) && vld[gnt];
  assign last       = acc && (bcnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
      bcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      prio  <= prio_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    prio_nxt  = prio;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (|vld) begin
          gnt_nxt   = pick(prio, vld);
          bcnt_nxt  = 2'd0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (last) begin
          // Re-arbitrate with the rotated priority so groups run back to back.
          prio_nxt = ~gnt;
          bcnt_nxt = 2'd0;
          if (|vld) gnt_nxt = pick(~gnt, vld);
          else      state_nxt = IDLE;
        end else if (acc) begin
          bcnt_nxt = bcnt + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_valid <= 1'b0;
      pk_data  <= 8'd0;
      pk_src   <= 1'b0;
      grp_done <= 1'b0;
    end else begin
      pk_valid <= acc;
      grp_done <= last;
      if (acc) begin
        pk_data <= dat[gnt];
        pk_src  <= gnt;
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_cnt
    grp_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (last && (gnt == 1'(s))),
      .cnt (cnt[s])
    );
  end

  assign grp_cnt0 = cnt[0];
  assign grp_cnt1 = cnt[1];
endmodule

// File: tb/tb_width_8to12_arb.sv
// Scoreboard bench for width_8to12_arb: per-source byte queues drive the requests,
// accepted bytes are queued as expected packer output and compared on pk_valid.
module tb_width_8to12_arb;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]       req0_data = 8'd0, req1_data = 8'd0;
  logic             req0_ready, req1_ready;
  logic             pk_valid, pk_src, grp_done, busy;
  logic [7:0]       pk_data;
  logic [CNT_W-1:0] grp_cnt0, grp_cnt1;

  width_8to12_arb #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pk_valid(pk_valid), .pk_data(pk_data), .pk_src(pk_src),
    .grp_done(grp_done), .busy(busy), .grp_cnt0(grp_cnt0), .grp_cnt1(grp_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic src; logic [7:0] data; logic done;} exp_t;

  int               checks = 0, errors = 0;
  exp_t             sb[$];
  logic [7:0]       q0[$], q1[$];
  logic [CNT_W-1:0] log0[$];
  logic [CNT_W-1:0] m0, m1;
  int               nacc0, nacc1;
  bit               hold0, hold1;
  bit               seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    chk("rdy_excl", 32'(req0_ready & req1_ready), 0);
    if (pk_valid) begin
      if (sb.size() == 0) chk("unexp_pk", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pk_data", pk_data, e.data);
        chk("pk_src", pk_src, e.src);
        chk("grp_done", grp_done, e.done);
        if (e.done) begin
          if (e.src) m1++;
          else begin
            m0++;
            log0.push_back(grp_cnt0);
          end
        end
      end
    end else chk("done_nopk", grp_done, 0);
    chk("cnt0", grp_cnt0, m0);
    chk("cnt1", grp_cnt1, m1);
  endtask

  task automatic drive();
    req0_valid = (q0.size() > 0) && !hold0;
    req1_valid = (q1.size() > 0) && !hold1;
    if (req0_valid) req0_data = q0[0];
    if (req1_valid) req1_data = q1[0];
    if (!rst && req0_valid && req0_ready) begin
      sb.push_back('{src: 1'b0, data: q0.pop_front(), done: (nacc0 % 3 == 2)});
      nacc0++;
    end
    if (!rst && req1_valid && req1_ready) begin
      sb.push_back('{src: 1'b1, data: q1.pop_front(), done: (nacc1 % 3 == 2)});
      nacc1++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive();
  endtask

  task automatic do_reset(input bit mon);
    @(negedge clk);
    if (mon) monitor();
    rst = 1'b1;
    q0.delete(); q1.delete(); sb.delete(); log0.delete();
    m0 = '0; m1 = '0; nacc0 = 0; nacc1 = 0; hold0 = 0; hold1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_pkv", pk_valid, 0);
    chk("rst_pkd", pk_data, 0);
    chk("rst_pks", pk_src, 0);
    chk("rst_done", grp_done, 0);
    chk("rst_cnt0", grp_cnt0, 0);
    chk("rst_cnt1", grp_cnt1, 0);
    rst = 1'b0;
    drive();
  endtask

  initial begin
    // Single source, one group: one idle cycle, then three accepted bytes
    do_reset(0);
    q0 = '{8'hA1, 8'hB2, 8'hC3};
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rdy", req0_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_rdy", req0_ready, 1);
      chk("t1_busy", busy, 1);
    end
    step(); step();
    chk("t1_cnt0", grp_cnt0, 1);
    chk("t1_sb", sb.size(), 0);

    // Both sources always valid: groups alternate with no gap
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'h10 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = pk_valid;
    end
    chk("t2_start", seen, 1);
    for (int k = 0; k < 12; k++) begin
      chk("t2_vld", pk_valid, 1);
      chk("t2_src", pk_src, (k / 3) % 2);
      step();
    end
    chk("t2_sb", sb.size(), 0);

    // Granted source 1 stalls mid-group; source 0 must not be served
    do_reset(1);
    q1 = '{8'h31, 8'h32, 8'h33};
    step(); step();
    q0 = '{8'h41, 8'h42, 8'h43};
    hold1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_rdy0", req0_ready, 0);
      chk("t3_rdy1", req1_ready, 1);
      chk("t3_busy", busy, 1);
      if (i > 0) begin
        chk("t3_pkv", pk_valid, 0);
        chk("t3_pkhold", pk_data, 8'h31);
      end
    end
    hold1 = 0;
    for (int i = 0; i < 10; i++) step();
    chk("t3_cnt0", grp_cnt0, 1);
    chk("t3_cnt1", grp_cnt1, 1);
    chk("t3_sb", sb.size(), 0);

    // Reset after two bytes discards the group; next group starts from source 0
    do_reset(1);
    q0 = '{8'h51, 8'h52, 8'h53};
    q1 = '{8'h61, 8'h62, 8'h63};
    step(); step(); step();
    do_reset(1);
    q0 = '{8'h71, 8'h72, 8'h73};
    q1 = '{8'h81, 8'h82, 8'h83};
    step(); step(); step();
    chk("t4_pkv", pk_valid, 1);
    chk("t4_src", pk_src, 0);
    chk("t4_data", pk_data, 8'h71);
    for (int i = 0; i < 12; i++) step();
    chk("t4_sb", sb.size(), 0);

    // Counter wrap with a 2-bit group counter
    do_reset(1);
    for (int i = 0; i < 15; i++) q0.push_back(8'h90 + 8'(i));
    for (int i = 0; i < 20; i++) step();
    chk("t5_ngrp", log0.size(), 5);
    if (log0.size() == 5) begin
      chk("t5_c0", log0[0], 1);
      chk("t5_c1", log0[1], 2);
      chk("t5_c2", log0[2], 3);
      chk("t5_c3", log0[3], 0);
      chk("t5_c4", log0[4], 1);
    end
    chk("t5_sb", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
